// File: rtl/lsu_dccm_arb.sv
// DCCM write-port arbiter: store buffer, DMA and ECC-correction writeback share one
// write port and are sequenced against the DC1 pipe read, with starvation-driven read stalls.
module lsu_dccm_arb #(
    parameter int DCCM_BITS        = 16,
    parameter int DCCM_FDATA_WIDTH = 39,
    parameter int DCCM_WIDTH_BITS  = 2,
    parameter int DCCM_BANK_BITS   = 3,
    parameter int STARVE_MAX       = 4
) (
    input  logic                        clk,
    input  logic                        rst_l,
    input  logic                        lsu_freeze_dc3,
    input  logic                        rd_vld_dc1,
    input  logic [DCCM_BITS-1:0]        rd_addr_lo_dc1,
    input  logic [DCCM_BITS-1:0]        rd_addr_hi_dc1,
    input  logic                        stbuf_req,
    input  logic [DCCM_BITS-1:0]        stbuf_addr,
    input  logic [DCCM_FDATA_WIDTH-1:0] stbuf_wdata,
    output logic                        stbuf_gnt,
    input  logic                        dma_req,
    input  logic [DCCM_BITS-1:0]        dma_addr,
    input  logic [DCCM_FDATA_WIDTH-1:0] dma_wdata,
    output logic                        dma_gnt,
    input  logic                        ecc_fix_vld,
    input  logic [DCCM_BITS-1:0]        ecc_fix_addr,
    input  logic [DCCM_FDATA_WIDTH-1:0] ecc_fix_data,
    output logic                        ecc_busy,
    output logic                        ecc_ovf,
    output logic                        rd_stall_dc1,
    output logic                        dccm_rden,
    output logic [DCCM_BITS-1:0]        dccm_rd_addr_lo,
    output logic [DCCM_BITS-1:0]        dccm_rd_addr_hi,
    output logic                        dccm_wren,
    output logic [DCCM_BITS-1:0]        dccm_wr_addr,
    output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_CNT = CNT_W'(STARVE_MAX);
    localparam int N_REQ   = 3;
    localparam int IDX_ECC = 0;
    localparam int IDX_DMA = 1;
    localparam int IDX_STB = 2;

    typedef logic [DCCM_BITS-1:0]        addr_t;
    typedef logic [DCCM_FDATA_WIDTH-1:0] data_t;
    typedef logic [DCCM_BANK_BITS-1:0]   bank_t;
    typedef enum logic { ECC_EMPTY, ECC_FULL } ecc_state_e;

    function automatic bank_t bank_of(input addr_t a);
        return a[DCCM_WIDTH_BITS +: DCCM_BANK_BITS];
    endfunction

    ecc_state_e           ecc_state_q, ecc_state_d;
    addr_t                ecc_addr_q, ecc_addr_d;
    data_t                ecc_data_q, ecc_data_d;
    logic                 ecc_ovf_q, ecc_ovf_d;
    logic [CNT_W-1:0]     cnt_q [N_REQ];
    logic [CNT_W-1:0]     cnt_d [N_REQ];

    addr_t                req_addr [N_REQ];
    data_t                req_data [N_REQ];
    logic [N_REQ-1:0]     pend, conf, starved, gnt;
    logic                 win_vld;
    logic [1:0]           win_idx;
    logic                 frozen;

    assign frozen            = lsu_freeze_dc3;
    assign req_addr[IDX_ECC] = ecc_addr_q;
    assign req_addr[IDX_DMA] = dma_addr;
    assign req_addr[IDX_STB] = stbuf_addr;
    assign req_data[IDX_ECC] = ecc_data_q;
    assign req_data[IDX_DMA] = dma_wdata;
    assign req_data[IDX_STB] = stbuf_wdata;
    assign pend              = {stbuf_req, dma_req, ecc_state_q == ECC_FULL};

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        conf    = '0;
        starved = '0;
        for (int i = 0; i < N_REQ; i++) begin
            conf[i]    = rd_vld_dc1 & ((bank_of(req_addr[i]) == bank_of(rd_addr_lo_dc1)) |
                                       (bank_of(req_addr[i]) == bank_of(rd_addr_hi_dc1)));
            starved[i] = pend[i] & (cnt_q[i] == STARVE_CNT);
        end
    end

    // Scan from lowest to highest priority so the last hit wins; starved pass overrides.
    always_comb begin
        win_vld = 1'b0;
        win_idx = 2'd0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (pend[i] & ~conf[i]) begin
                win_vld = 1'b1;
                win_idx = 2'(i);
            end
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (starved[i]) begin
                win_vld = 1'b1;
                win_idx = 2'(i);
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (~frozen & win_vld) gnt[win_idx] = 1'b1;
    end

    assign stbuf_gnt       = gnt[IDX_STB];
    assign dma_gnt         = gnt[IDX_DMA];
    assign rd_stall_dc1    = ~frozen & rd_vld_dc1 & win_vld & starved[win_idx] & conf[win_idx];
    assign dccm_rden       = rd_vld_dc1 & ~rd_stall_dc1;
    assign dccm_rd_addr_lo = rd_addr_lo_dc1;
    assign dccm_rd_addr_hi = rd_addr_hi_dc1;
    assign dccm_wren       = ~frozen & win_vld;
    assign dccm_wr_addr    = win_vld ? req_addr[win_idx] : '0;
    assign dccm_wr_data    = win_vld ? req_data[win_idx] : '0;
    assign ecc_busy        = (ecc_state_q == ECC_FULL);
    assign ecc_ovf         = ecc_ovf_q;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!frozen) begin
                if (!pend[i] || gnt[i])          cnt_d[i] = '0;
                else if (cnt_q[i] != STARVE_CNT) cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        ecc_state_d = ecc_state_q;
        ecc_addr_d  = ecc_addr_q;
        ecc_data_d  = ecc_data_q;
        ecc_ovf_d   = ecc_ovf_q;
        case (ecc_state_q)
            ECC_EMPTY: begin
                if (ecc_fix_vld) begin
                    ecc_state_d = ECC_FULL;
                    ecc_addr_d  = ecc_fix_addr;
                    ecc_data_d  = ecc_fix_data;
                end
            end
            ECC_FULL: begin
                if (gnt[IDX_ECC]) begin
                    if (ecc_fix_vld) begin
                        ecc_addr_d = ecc_fix_addr;
                        ecc_data_d = ecc_fix_data;
                    end else begin
                        ecc_state_d = ECC_EMPTY;
                    end
                end else if (ecc_fix_vld) begin
                    ecc_ovf_d = 1'b1;
                end
            end
            default: ecc_state_d = ECC_EMPTY;
        endcase
    end

    // NOTE: state registers use non-blocking assignments; the small entry buffer is reset
    // too so a stale address can never reach the write mux.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            ecc_state_q <= ECC_EMPTY;
            ecc_addr_q  <= '0;
            ecc_data_q  <= '0;
            ecc_ovf_q   <= 1'b0;
            for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
        end else begin
            ecc_state_q <= ecc_state_d;
            ecc_addr_q  <= ecc_addr_d;
            ecc_data_q  <= ecc_data_d;
            ecc_ovf_q   <= ecc_ovf_d;
            for (int i = 0; i < N_REQ; i++) cnt_q[i] <= cnt_d[i];
        end
    end

endmodule

// File: doc/lsu_dccm_arb.md
Name: lsu_dccm_arb

Overview:
- Arbiter for the single DCCM write port, shared by three writers: the store-buffer commit, DMA writes, and the ECC single-bit-error correction writeback.
- It sequences those writes against the LSU DC1 pipe read, which owns the lo/hi bank read addresses.
- It holds a one-entry ECC-correction buffer and per-requester starvation counters.
- When a write starves, it stalls the DC1 read so the write can take the port.

Parameters:
- DCCM_BITS, 16, DCCM byte-address width.
- DCCM_FDATA_WIDTH, 39, data+ECC width per bank.
- DCCM_WIDTH_BITS, 2, log2 of bank byte width.
- DCCM_BANK_BITS, 3, bank-select bit count.
- STARVE_MAX, 4, loss count at which a writer becomes starved (>=1).

Ports:
- clk  in  1  core clock
- rst_l  in  1  asynchronous active-low reset
- lsu_freeze_dc3  in  1  freeze; blocks all grants
- rd_vld_dc1  in  1  DC1 pipe wants a DCCM read
- rd_addr_lo_dc1  in  DCCM_BITS  lo-bank read address
- rd_addr_hi_dc1  in  DCCM_BITS  hi-bank read address
- stbuf_req  in  1  store-buffer write request
- stbuf_addr  in  DCCM_BITS  store-buffer write address
- stbuf_wdata  in  DCCM_FDATA_WIDTH  store-buffer write data
- stbuf_gnt  out  1  store-buffer grant
- dma_req  in  1  DMA write request
- dma_addr  in  DCCM_BITS  DMA write address
- dma_wdata  in  DCCM_FDATA_WIDTH  DMA write data
- dma_gnt  out  1  DMA grant
- ecc_fix_vld  in  1  correction-writeback push
- ecc_fix_addr  in  DCCM_BITS  corrected address
- ecc_fix_data  in  DCCM_FDATA_WIDTH  corrected data+ECC
- ecc_busy  out  1  correction buffer full
- ecc_ovf  out  1  sticky: correction dropped
- rd_stall_dc1  out  1  DC1 read suppressed this cycle
- dccm_rden  out  1  DCCM read enable
- dccm_rd_addr_lo  out  DCCM_BITS  DCCM lo-bank read address
- dccm_rd_addr_hi  out  DCCM_BITS  DCCM hi-bank read address
- dccm_wren  out  1  DCCM write enable
- dccm_wr_addr  out  DCCM_BITS  DCCM write address
- dccm_wr_data  out  DCCM_FDATA_WIDTH  DCCM write data

Behaviour:
- Reset (async, rst_l=0): ECC buffer empty, ecc_busy=0, ecc_ovf=0, all three wait counters=0.
  - Combinational outputs then follow inputs with an empty buffer; no grant is possible while frozen.
- Read addresses: dccm_rd_addr_lo/hi are always rd_addr_lo/hi_dc1 passed through.
- Handshake: req/addr/data are held until gnt. gnt is a same-cycle combinational pulse and coincides with dccm_wren.
  - At most one gnt per cycle. The ECC buffer grant is internal.
- Conflict: wbank = addr[DCCM_WIDTH_BITS +: DCCM_BANK_BITS]. A write conflicts when rd_vld_dc1 and wbank equals the bank of rd_addr_lo or of rd_addr_hi.
- Starved: a pending requester whose wait counter == STARVE_MAX.
- Write winner selection:
  - Starved requesters beat non-starved ones.
  - Within the same class the fixed order is ECC > DMA > stbuf.
  - Any conflicting non-starved candidate is skipped, and the next eligible candidate wins.
- rd_stall_dc1 = ~freeze & rd_vld_dc1 & the selected winner is starved & it conflicts.
- dccm_rden = rd_vld_dc1 & ~rd_stall_dc1. A read is never blocked by freeze here.
- dccm_wren = ~freeze & a winner exists. dccm_wr_addr/data are muxed from the winner; they are 0 when there is no winner.
- Wait counters, one per requester:
  - +1 per cycle while the requester is pending, ungranted, and not frozen, saturating at STARVE_MAX.
  - Cleared on grant.
  - Held during freeze.
  - Cleared when the request drops without a grant.
- ECC buffer, two states (EMPTY, FULL):
  - EMPTY & ecc_fix_vld: latch addr/data, go FULL (ecc_busy=1 next cycle).
  - FULL & grant & ecc_fix_vld: latch the new entry, stay FULL.
  - FULL & grant, no push: go EMPTY.
  - FULL & no grant & ecc_fix_vld: push dropped, ecc_ovf<=1 (sticky until reset).
- Simultaneous stbuf_req & dma_req, neither starved, no conflict: DMA wins, and the stbuf counter increments.

Test Plan:
- STARVE_MAX=4. Reset, then stbuf_req=1, addr=0x0010, no read -> stbuf_gnt=1 and dccm_wren=1 in the same cycle, wr_addr=0x0010.
- stbuf_req and dma_req held, no read -> dma_gnt in cycle 0; after DMA drops, stbuf_gnt in cycle 1; stbuf counter reaches 1 then clears.
- rd_vld_dc1=1 with rd_addr_lo=0x0010 (bank 4) held constant, stbuf_addr=0x0012 (bank 4):
  - cycles 0-3: no grant, dccm_rden=1.
  - cycle 4: rd_stall_dc1=1, dccm_rden=0, stbuf_gnt=1.
  - cycle 5: rd_stall_dc1=0.
- ecc_fix_vld pulse addr=0x0100, then ecc_fix_vld again next cycle while a starved DMA holds the port -> first entry is granted only after DMA; second push is dropped; ecc_ovf=1 and stays 1.
- lsu_freeze_dc3=1 for 3 cycles with stbuf_req=1 (counter=2) -> no gnt and counter stays 2; after unfreeze, gnt in the first cycle.
- Assert rst_l=0 mid-operation (buffer FULL, ecc_ovf=1, counters=3) -> ecc_busy=0, ecc_ovf=0, counters=0 immediately and asynchronously; no dccm_wren on the first edge after release unless a req is present.
